adder_result_checker: RTL and testbench

Self-checking sink for the pipelined adder test harness. It takes the same operand stream the stimulus counters drive into the adder and, LATENCY cycles later, the adder's {cout,sum} output. It compares each result against a locally computed reference sum and keeps pass/error statistics. It also captures the first mismatch, which gives on-board pass/fail visibility without a simulator.

---
 rtl/adder_result_checker.sv | 140 ++++++++++++++
 tb/tb_adder_result_checker.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_checker.sv
// adder_result_checker: self-checking sink for the pipelined adder harness.
// Delays a local reference sum by LATENCY and compares it against res.
module adder_result_checker #(
  parameter int WIDTH       = 128,
  parameter int LATENCY     = 4,
  parameter int ERR_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  input  logic [WIDTH:0]   res,
  output logic [31:0]      chk_cnt,
  output logic [ERR_W-1:0] err_cnt,
  output logic             mismatch,
  output logic             fail,
  output logic [WIDTH:0]   err_exp,
  output logic [WIDTH:0]   err_got,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [WIDTH:0]     exp_q [LATENCY];
  logic [WIDTH:0]     exp_d [LATENCY];
  logic [WIDTH:0]     exp_in;

  logic [31:0]        chk_q, chk_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               mis_q, mis_d;
  logic               fail_q, fail_d;
  logic [WIDTH:0]     eexp_q, eexp_d;
  logic [WIDTH:0]     egot_q, egot_d;

  logic               do_cmp;
  logic               hit;
  logic               miss;

  assign exp_in = {1'b0, op_a} + {1'b0, op_b}
                + (WIDTH+1)'(op_cin);

  // The line freezes only in HALT; bubbles shift in as invalid.
  always_comb begin
    vld_d = vld_q;
    exp_d = exp_q;
    if (state_q != HALT) begin
      vld_d[0] = op_valid;
      exp_d[0] = exp_in;
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        exp_d[i] = exp_q[i-1];
      end
    end
  end

  assign do_cmp = (state_q == RUN)
                && vld_q[LATENCY-1];
  assign hit    = do_cmp
                && (res == exp_q[LATENCY-1]);
  assign miss   = do_cmp
                && (res != exp_q[LATENCY-1]);

  always_comb begin
    state_d = state_q;
    chk_d   = chk_q;
    err_d   = err_q;
    mis_d   = 1'b0;
    fail_d  = fail_q;
    eexp_d  = eexp_q;
    egot_d  = egot_q;
    unique case (state_q)
      IDLE: begin
        if (op_valid) state_d = RUN;
      end
      RUN: begin
        if (hit && chk_q != '1)
          chk_d = chk_q + 32'd1;
        if (miss) begin
          mis_d = 1'b1;
          if (err_q != '1)
            err_d = err_q + ERR_W'(1);
          if (!fail_q) begin
            fail_d = 1'b1;
            eexp_d = exp_q[LATENCY-1];
            egot_d = res;
          end
          if (STOP_ON_ERR) state_d = HALT;
        end
      end
      HALT: begin
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vld_q   <= '0;
      chk_q   <= '0;
      err_q   <= '0;
      mis_q   <= 1'b0;
      fail_q  <= 1'b0;
      eexp_q  <= '0;
      egot_q  <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      fail_q  <= fail_d;
      eexp_q  <= eexp_d;
      egot_q  <= egot_d;
    end
  end

  // Payload is qualified by vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    exp_q <= exp_d;
  end

  assign chk_cnt  = chk_q;
  assign err_cnt  = err_q;
  assign mismatch = mis_q;
  assign fail     = fail_q;
  assign err_exp  = eexp_q;
  assign err_got  = egot_q;
  assign state    = state_q;

endmodule

// File: tb/tb_adder_result_checker.sv
// tb_adder_result_checker: scoreboard bench driving three checker builds
// (default, stop-on-error, 2-bit error counter) from one shared stream.
`timescale 1ns/1ps
module tb_adder_result_checker;

  localparam int W = 128;
  localparam int L = 4;

  typedef logic [W:0] res_t;
  typedef struct {
    bit   e;
    res_t x;
    res_t g;
  } sb_t;

  localparam res_t CARRY = {1'b1, {(W-1){1'b0}}, 1'b1};
  localparam res_t JUNK  = res_t'(129'hBAD0_BAD0);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         op_valid = 1'b0;
  logic         op_cin = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  res_t         res = '0;

  logic [31:0] a_chk, b_chk, c_chk;
  logic [15:0] a_err, b_err;
  logic [1:0]  c_err;
  logic        a_mis, b_mis, c_mis;
  logic        a_fail, b_fail, c_fail;
  res_t        a_exp, b_exp, c_exp;
  res_t        a_got, b_got, c_got;
  logic [1:0]  a_st, b_st, c_st;

  adder_result_checker #(
    .WIDTH(W), .LATENCY(L), .ERR_W(16),
    .STOP_ON_ERR(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .op_valid(op_valid),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .res(res), .chk_cnt(a_chk), .err_cnt(a_err),
    .mismatch(a_mis), .fail(a_fail),
    .err_exp(a_exp), .err_got(a_got), .state(a_st)
  );

  adder_result_checker #(
    .WIDTH(W), .LATENCY(L), .ERR_W(16),
    .STOP_ON_ERR(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .op_valid(op_valid),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .res(res), .chk_cnt(b_chk), .err_cnt(b_err),
    .mismatch(b_mis), .fail(b_fail),
    .err_exp(b_exp), .err_got(b_got), .state(b_st)
  );

  adder_result_checker #(
    .WIDTH(W), .LATENCY(L), .ERR_W(2),
    .STOP_ON_ERR(1'b0)
  ) dut_c (
    .clk(clk), .rst(rst), .op_valid(op_valid),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .res(res), .chk_cnt(c_chk), .err_cnt(c_err),
    .mismatch(c_mis), .fail(c_fail),
    .err_exp(c_exp), .err_got(c_got), .state(c_st)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int a_mis_n = 0;
  int b_mis_n = 0;
  int c_mis_n = 0;
  int a_mis_cyc[$];
  sb_t  sbq[$];
  res_t line[L];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, res_t got, res_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // One cycle: present op and the result due for the op L cycles back.
  task automatic step(bit v, logic [W-1:0] a,
                      logic [W-1:0] b, bit cin,
                      res_t r, bit push);
    res_t e;
    e = {1'b0, a} + {1'b0, b} + res_t'(cin);
    op_valid = v;
    op_a     = a;
    op_b     = b;
    op_cin   = cin;
    res      = line[L-1];
    for (int i = L-1; i > 0; i--) line[i] = line[i-1];
    line[0] = r;
    if (v && push) sbq.push_back('{e: (r !== e), x: e, g: r});
    @(posedge clk);
    #2;
  endtask

  task automatic op(logic [W-1:0] a, logic [W-1:0] b,
                    bit cin, bit bad);
    res_t e;
    e = {1'b0, a} + {1'b0, b} + res_t'(cin);
    step(1'b1, a, b, cin, bad ? (e ^ res_t'(1)) : e, 1'b1);
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, '0, '0, 1'b0, JUNK, 1'b0);
  endtask

  task automatic do_reset();
    sbq.delete();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  // Monitor: every result event on dut_a pops one scoreboard entry.
  initial begin : mon
    logic [31:0] prev;
    sb_t it;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        prev = '0;
      end else begin
        if (b_mis === 1'b1) b_mis_n++;
        if (c_mis === 1'b1) c_mis_n++;
        if (a_mis === 1'b1 || a_chk !== prev) begin
          if (a_mis === 1'b1) begin
            a_mis_n++;
            a_mis_cyc.push_back(cyc);
          end
          if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_extra: chk=%0d mismatch=%0b with no op due",
                     a_chk, a_mis);
          end else begin
            it = sbq.pop_front();
            check("sb_mismatch", res_t'(a_mis), res_t'(it.e));
            if (!it.e)
              check("sb_chk_inc", res_t'(a_chk), res_t'(prev + 32'd1));
          end
        end
        prev = a_chk;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: run exceeded time budget");
    $fatal(1);
  end

  initial begin : main
    for (int i = 0; i < L; i++) line[i] = JUNK;

    // Reset values
    idle(2);
    check("rst_chk", res_t'(a_chk), '0);
    check("rst_err", res_t'(a_err), '0);
    check("rst_mis", res_t'(a_mis), '0);
    check("rst_fail", res_t'(a_fail), '0);
    check("rst_exp", a_exp, '0);
    check("rst_got", a_got, '0);
    check("rst_state", res_t'(a_st), res_t'(0));
    rst = 1'b0;
    idle(3);
    check("idle_state", res_t'(a_st), res_t'(0));
    check("idle_chk", res_t'(a_chk), '0);

    // Continuous stream a=0..99, b=5
    for (int i = 0; i < 100; i++) begin
      op(W'(i), W'(5), 1'b0, 1'b0);
      if (i == 0) check("run_entry", res_t'(a_st), res_t'(1));
      if (i == 9) check("lat_chk_op9", res_t'(a_chk), res_t'(6));
    end
    idle(8);
    check("p1_chk", res_t'(a_chk), res_t'(100));
    check("p1_err", res_t'(a_err), '0);
    check("p1_fail", res_t'(a_fail), '0);
    check("p1_state", res_t'(a_st), res_t'(1));
    check("p1_b_chk", res_t'(b_chk), res_t'(100));
    check("p1_c_chk", res_t'(c_chk), res_t'(100));

    // Carry-out boundary
    do_reset();
    a_mis_n = 0;
    op('1, W'(1), 1'b1, 1'b0);
    step(1'b1, '1, W'(1), 1'b1, res_t'(1), 1'b1);
    idle(6);
    check("cy_chk", res_t'(a_chk), res_t'(1));
    check("cy_err", res_t'(a_err), res_t'(1));
    check("cy_fail", res_t'(a_fail), res_t'(1));
    check("cy_exp", a_exp, CARRY);
    check("cy_got", a_got, res_t'(1));
    check("cy_pulses", res_t'(a_mis_n), res_t'(1));
    check("cy_b_state", res_t'(b_st), res_t'(2));

    // Injected errors on ops 3 and 7
    do_reset();
    a_mis_n = 0;
    b_mis_n = 0;
    a_mis_cyc.delete();
    for (int i = 0; i < 20; i++)
      op(W'(3*i + 1), W'(i), i[0], (i == 3 || i == 7));
    idle(6);
    check("inj_chk", res_t'(a_chk), res_t'(18));
    check("inj_err", res_t'(a_err), res_t'(2));
    check("inj_exp", a_exp, res_t'(14));
    check("inj_got", a_got, res_t'(15));
    check("inj_pulses", res_t'(a_mis_n), res_t'(2));
    if (a_mis_cyc.size() == 2)
      check("inj_gap", res_t'(a_mis_cyc[1] - a_mis_cyc[0]), res_t'(4));
    check("stop_state", res_t'(b_st), res_t'(2));
    check("stop_chk", res_t'(b_chk), res_t'(3));
    check("stop_err", res_t'(b_err), res_t'(1));
    check("stop_exp", b_exp, res_t'(14));
    check("stop_pulses", res_t'(b_mis_n), res_t'(1));
    idle(5);
    check("halt_hold_chk", res_t'(b_chk), res_t'(3));

    // Bubbles, then reset with ops in flight
    do_reset();
    a_mis_n = 0;
    op(W'(100), W'(1), 1'b0, 1'b0);
    idle(2);
    op(W'(200), W'(2), 1'b1, 1'b0);
    op(W'(300), W'(3), 1'b0, 1'b0);
    idle(6);
    check("bub_chk", res_t'(a_chk), res_t'(3));
    check("bub_err", res_t'(a_err), '0);
    for (int i = 0; i < 3; i++) op(W'(i), W'(9), 1'b0, 1'b1);
    do_reset();
    check("mid_rst_chk", res_t'(a_chk), '0);
    check("mid_rst_state", res_t'(a_st), res_t'(0));
    check("mid_rst_fail", res_t'(a_fail), '0);
    idle(6);
    check("post_rst_chk", res_t'(a_chk), '0);
    check("post_rst_err", res_t'(a_err), '0);
    check("post_rst_fail", res_t'(a_fail), '0);
    check("post_rst_state", res_t'(a_st), res_t'(0));
    check("post_rst_pulses", res_t'(a_mis_n), '0);

    // Error-counter saturation on the 2-bit build
    do_reset();
    c_mis_n = 0;
    for (int i = 0; i < 6; i++) op(W'(i), W'(7), 1'b0, 1'b1);
    idle(6);
    check("sat_c_err", res_t'(c_err), res_t'(3));
    check("sat_c_pulses", res_t'(c_mis_n), res_t'(6));
    check("sat_c_fail", res_t'(c_fail), res_t'(1));
    check("sat_a_err", res_t'(a_err), res_t'(6));
    check("sat_b_err", res_t'(b_err), res_t'(1));

    check("sb_drain", res_t'(sbq.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
